// File: rtl/sram_pkg.sv
// Shared types and constants for the external 256Kx16 asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_AW           = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned BE_W              = 4;
  localparam int unsigned ACCESS_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_WR_SET,
    ST_WR_STB,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  // HI half lives at the even halfword address and carries word bits [31:16].
  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } half_e;

  // Expand a halfword's two byte enables into a 16-bit data mask.
  function automatic logic [SRAM_DW-1:0] lane_mask(input logic [1:0] en);
    return {{(SRAM_DW/2){en[1]}}, {(SRAM_DW/2){en[0]}}};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side word request / completion handshake of the SRAM controller.
interface sram_ctrl_if;
  import sram_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] byte_addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   byte_en;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, byte_addr, wdata, byte_en,
    input  busy, done, rdata
  );

  modport slave (
    input  req, we, byte_addr, wdata, byte_en,
    output busy, done, rdata
  );

endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit core request into up to two 16-bit asynchronous SRAM cycles
// (big-endian: even halfword = bits [31:16]); every bus output is a flop.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  sram_ctrl_if.slave         core,
  output logic [SRAM_AW-1:0] addr,
  inout  wire  [SRAM_DW-1:0] data,
  output logic               wre,
  output logic               oute,
  output logic               chip_en,
  output logic               hb_mask,
  output logic               lb_mask
);

  localparam int unsigned CW   = $clog2(ACCESS_CYCLES + 1);
  localparam int unsigned WA_W = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_e              state_q, state_d;
  half_e               half_q, half_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [WA_W-1:0]     wa_q, wa_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [SRAM_DW-1:0]  dout_q, dout_d;
  logic                drv_q, drv_d;
  logic                wre_q, wre_d;
  logic                oute_q, oute_d;
  logic                ce_q, ce_d;
  logic                hb_q, hb_d;
  logic                lb_q, lb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [SRAM_DW-1:0]  rd_hw_c;
  state_e              after_hi_c;
  logic [1:0]          lane_en_c;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{core.byte_addr[WORD_W-1:19], core.byte_addr[1:0]};

  // Halfword currently on the bus with its disabled bytes forced to zero.
  assign rd_hw_c = data & lane_mask((half_q == HALF_HI) ? be_q[3:2] : be_q[1:0]);

  // Where to go once the HI half (or a skipped HI half) is finished.
  assign after_hi_c = (|be_q[1:0]) ? (we_q ? ST_WR_SET : ST_RD_LO) : ST_DONE;

  // State register, captured request and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      half_q  <= HALF_HI;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      drv_q   <= 1'b0;
      wre_q   <= 1'b1;
      oute_q  <= 1'b1;
      ce_q    <= 1'b1;
      hb_q    <= 1'b1;
      lb_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      drv_q   <= drv_d;
      wre_q   <= wre_d;
      oute_q  <= oute_d;
      ce_q    <= ce_d;
      hb_q    <= hb_d;
      lb_q    <= lb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state, then the bus outputs decoded from the state being entered.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    wa_d      = wa_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    dout_d    = dout_q;
    drv_d     = 1'b0;
    wre_d     = 1'b1;
    oute_d    = 1'b1;
    ce_d      = 1'b1;
    hb_d      = 1'b1;
    lb_d      = 1'b1;
    lane_en_c = 2'b00;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && !done_q) begin
          // Empty request: one busy cycle already spent, now report completion.
          done_d = 1'b1;
        end else if (core.req) begin
          we_d    = core.we;
          wa_d    = core.byte_addr[18:2];
          wdata_d = core.wdata;
          be_d    = core.byte_en;
          rdata_d = '0;
          cnt_d   = '0;
          if (|core.byte_en[3:2]) begin
            half_d  = HALF_HI;
            state_d = core.we ? ST_WR_SET : ST_RD_HI;
          end else if (|core.byte_en[1:0]) begin
            half_d  = HALF_LO;
            state_d = core.we ? ST_WR_SET : ST_RD_LO;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_HI, ST_RD_LO: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (state_q == ST_RD_HI) begin
            rdata_d[31:16] = rd_hw_c;
            state_d        = after_hi_c;
            half_d         = HALF_LO;
            done_d         = (after_hi_c == ST_DONE);
          end else begin
            rdata_d[15:0] = rd_hw_c;
            state_d       = ST_DONE;
            done_d        = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WR_SET: begin
        state_d = ST_WR_STB;
        cnt_d   = '0;
      end

      ST_WR_STB: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WR_HOLD: begin
        if (half_q == HALF_HI) begin
          state_d = after_hi_c;
          half_d  = HALF_LO;
          done_d  = (after_hi_c == ST_DONE);
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    lane_en_c = (half_d == HALF_HI) ? be_d[3:2] : be_d[1:0];

    unique case (state_d)
      ST_RD_HI, ST_RD_LO: begin
        ce_d   = 1'b0;
        oute_d = 1'b0;
        addr_d = {wa_d, half_d == HALF_LO};
        hb_d   = ~lane_en_c[1];
        lb_d   = ~lane_en_c[0];
      end
      ST_WR_SET, ST_WR_STB, ST_WR_HOLD: begin
        ce_d   = 1'b0;
        drv_d  = 1'b1;
        wre_d  = (state_d != ST_WR_STB);
        addr_d = {wa_d, half_d == HALF_LO};
        dout_d = (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
        hb_d   = ~lane_en_c[1];
        lb_d   = ~lane_en_c[0];
      end
      default: begin
      end
    endcase

    busy_d = (state_d != ST_IDLE) && !done_d;
  end

  assign data       = drv_q ? dout_q : {SRAM_DW{1'bz}};
  assign addr       = addr_q;
  assign wre        = wre_q;
  assign oute       = oute_q;
  assign chip_en    = ce_q;
  assign hb_mask    = hb_q;
  assign lb_mask    = lb_q;
  assign core.busy  = busy_q;
  assign core.done  = done_q;
  assign core.rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed vector table, multi-cycle corner sequences and
// random requests checked against a word-level memory image.
module tb_sram_ctrl;

  localparam int N = 2;
  localparam int MEM_WORDS = 262144;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sram_ctrl_if core ();
  sram_ctrl_if core1 ();

  logic [17:0] addr, addr1;
  tri1  [15:0] data, data1;
  logic wre, oute, chip_en, hb_mask, lb_mask;
  logic wre1, oute1, chip_en1, hb_mask1, lb_mask1;

  sram_ctrl #(.ACCESS_CYCLES(N)) u_dut (
    .clock(clock), .reset(reset), .core(core), .addr(addr), .data(data),
    .wre(wre), .oute(oute), .chip_en(chip_en), .hb_mask(hb_mask), .lb_mask(lb_mask)
  );

  sram_ctrl #(.ACCESS_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(reset), .core(core1), .addr(addr1), .data(data1),
    .wre(wre1), .oute(oute1), .chip_en(chip_en1), .hb_mask(hb_mask1), .lb_mask(lb_mask1)
  );

  // Ram device: drives data while selected with output enable, writes masked bytes.
  logic [15:0] mem [0:MEM_WORDS-1];
  logic [15:0] ref_mem [0:MEM_WORDS-1];
  assign data  = (!chip_en && !oute) ? mem[addr] : 16'hzzzz;
  assign data1 = (!chip_en1 && !oute1) ? (addr1[15:0] ^ 16'h5A5A) : 16'hzzzz;

  always @(negedge clock) begin
    if (!chip_en && !wre) begin
      if (!hb_mask) mem[addr][15:8] = data[15:8];
      if (!lb_mask) mem[addr][7:0]  = data[7:0];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && !oute) check("rw_overlap_wre", {31'd0, wre}, 32'd1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int          lat;
    logic [31:0] rd;
    int          oute_lo;
    int          wre_lo;
    bit          ce_seen;
    logic [17:0] a_first;
    logic [17:0] a_last;
    logic        hb_first;
    logic        lb_first;
    logic        busy_at_done;
    logic        done_next;
  } trace_t;

  typedef struct {
    logic        we;
    logic [31:0] ba;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_strb;
    bit          exp_ce;
    logic [17:0] exp_a0;
    logic [17:0] exp_a1;
    logic        exp_hb;
    logic        exp_lb;
  } vec_t;

  function automatic logic [15:0] lanes(input logic [1:0] e);
    return {{8{e[1]}}, {8{e[0]}}};
  endfunction

  task automatic ref_write(input logic [16:0] w, input logic [31:0] d, input logic [3:0] be);
    if (be[3]) ref_mem[{w, 1'b0}][15:8] = d[31:24];
    if (be[2]) ref_mem[{w, 1'b0}][7:0]  = d[23:16];
    if (be[1]) ref_mem[{w, 1'b1}][15:8] = d[15:8];
    if (be[0]) ref_mem[{w, 1'b1}][7:0]  = d[7:0];
  endtask

  // One request on u_dut; k counts edges after the accepting edge E.
  task automatic run_req(input logic w, input logic [31:0] ba, input logic [31:0] wd,
                         input logic [3:0] be, output trace_t t);
    t = '{lat: -1, rd: 32'h0, oute_lo: 0, wre_lo: 0, ce_seen: 1'b0, a_first: 18'h0,
          a_last: 18'h0, hb_first: 1'b1, lb_first: 1'b1, busy_at_done: 1'b1, done_next: 1'b1};
    @(negedge clock);
    core.req = 1'b1; core.we = w; core.byte_addr = ba; core.wdata = wd; core.byte_en = be;
    @(posedge clock); #1;
    core.req = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!oute) t.oute_lo++;
      if (!wre) t.wre_lo++;
      if (!chip_en) begin
        if (!t.ce_seen) begin
          t.a_first = addr; t.hb_first = hb_mask; t.lb_first = lb_mask;
        end
        t.ce_seen = 1'b1;
        t.a_last  = addr;
      end
      if (core.done) begin
        t.lat = k; t.rd = core.rdata; t.busy_at_done = core.busy;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    t.done_next = core.done;
  endtask

  vec_t   vecs [9];
  trace_t tr;
  int     exp_lat, exp_strb, k;
  logic [16:0] widx;
  logic [31:0] rba, rwd, exp_rd;
  logic [3:0]  rbe;
  logic        rw, seen;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0, 4'hF, 1'b1, 32'h2008_000A, 4, 4, 1'b1, 18'h4, 18'h5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 8, 4, 1'b1, 18'h8, 18'h9, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'h0000_AB00, 4'h2, 1'b0, 32'h0, 4, 2, 1'b1, 18'hB, 18'hB, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0014, 32'h0, 4'hF, 1'b1, 32'h1234_AB78, 4, 4, 1'b1, 18'hA, 18'hB, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 4, 4, 1'b1, 18'h8, 18'h9, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'h0000_0000, 1, 0, 1'b0, 18'h0, 18'h0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0010, 32'h0, 4'h9, 1'b1, 32'hDE00_00EF, 4, 4, 1'b1, 18'h8, 18'h9, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'h0077_0000, 4'h4, 1'b0, 32'h0, 4, 2, 1'b1, 18'h0, 18'h0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'hFFF8_0003, 32'h0, 4'hF, 1'b1, 32'h0077_0000, 4, 4, 1'b1, 18'h0, 18'h1, 1'b0, 1'b0};

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = 16'h0; ref_mem[i] = 16'h0;
    end
    mem[4] = 16'h2008; mem[5] = 16'h000A; mem[10] = 16'h1234; mem[11] = 16'h5678;
    ref_mem[4] = 16'h2008; ref_mem[5] = 16'h000A; ref_mem[10] = 16'h1234; ref_mem[11] = 16'h5678;

    core.req = 1'b0; core.we = 1'b0; core.byte_addr = '0; core.wdata = '0; core.byte_en = '0;
    core1.req = 1'b0; core1.we = 1'b0; core1.byte_addr = '0; core1.wdata = '0; core1.byte_en = '0;

    // Reset held across edges, then released: idle bus before the first edge.
    #32;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_strobes", {27'd0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h1F);
    check("rst_data_z", {16'd0, data}, 32'hFFFF);
    check("rst_busy_done", {30'd0, core.busy, core.done}, 32'h0);
    check("rst_addr", {14'd0, addr}, 32'h0);
    check("rst_rdata", core.rdata, 32'h0);

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].we, vecs[i].ba, vecs[i].wd, vecs[i].be, tr);
      if (vecs[i].we) ref_write(vecs[i].ba[18:2], vecs[i].wd, vecs[i].be);
      check($sformatf("v%0d_latency", i), 32'(tr.lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_strobe_cycles", i), 32'(vecs[i].we ? tr.wre_lo : tr.oute_lo),
            32'(vecs[i].exp_strb));
      check($sformatf("v%0d_chip_en_seen", i), {31'd0, tr.ce_seen}, {31'd0, vecs[i].exp_ce});
      check($sformatf("v%0d_busy_in_done", i), {31'd0, tr.busy_at_done}, 32'd0);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, tr.done_next}, 32'd0);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), tr.rd, vecs[i].exp_rd);
      if (vecs[i].exp_ce) begin
        check($sformatf("v%0d_addr_first", i), {14'd0, tr.a_first}, {14'd0, vecs[i].exp_a0});
        check($sformatf("v%0d_addr_last", i), {14'd0, tr.a_last}, {14'd0, vecs[i].exp_a1});
        check($sformatf("v%0d_masks", i), {30'd0, tr.hb_first, tr.lb_first},
              {30'd0, vecs[i].exp_hb, vecs[i].exp_lb});
      end
    end

    // Full-word read with a single access cycle per strobe.
    @(negedge clock);
    core1.req = 1'b1; core1.we = 1'b0; core1.byte_addr = 32'h8; core1.byte_en = 4'hF;
    @(posedge clock); #1;
    core1.req = 1'b0;
    exp_lat = -1; exp_strb = 0;
    for (int j = 0; j < 50; j++) begin
      if (!oute1) exp_strb++;
      if (core1.done) begin exp_lat = j; break; end
      @(posedge clock); #1;
    end
    check("n1_latency", 32'(exp_lat), 32'd2);
    check("n1_oute_cycles", 32'(exp_strb), 32'd2);
    check("n1_rdata", core1.rdata, 32'h5A5E_5A5F);

    // Reset asserted mid-cycle while the write strobe is low.
    @(negedge clock);
    core.req = 1'b1; core.we = 1'b1; core.byte_addr = 32'h40; core.wdata = 32'hCAFE_F00D; core.byte_en = 4'hF;
    @(posedge clock); #1;
    core.req = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (!wre) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
    check("wr_stb_reached", {31'd0, seen}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_strobes", {29'd0, wre, chip_en, oute}, 32'h7);
    check("abort_data_z", {16'd0, data}, 32'hFFFF);
    check("abort_busy", {31'd0, core.busy}, 32'd0);
    check("abort_addr", {14'd0, addr}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Write then read with req held high: read accepted on the edge ending DONE.
    @(negedge clock);
    core.req = 1'b1; core.we = 1'b1; core.byte_addr = 32'h40; core.wdata = 32'hCAFE_F00D; core.byte_en = 4'hF;
    @(posedge clock); #1;
    core.we = 1'b0; core.wdata = 32'h0;
    ref_write(17'h10, 32'hCAFE_F00D, 4'hF);
    k = -1;
    for (int j = 0; j < 50; j++) begin
      if (core.done) begin k = j; break; end
      @(posedge clock); #1;
    end
    check("b2b_write_latency", 32'(k), 32'(2 * N + 4));
    check("b2b_done_bus_idle", {15'd0, oute, data}, 32'h1FFFF);
    @(posedge clock); #1;
    check("b2b_accept_busy", {31'd0, core.busy}, 32'd1);
    check("b2b_accept_oute", {31'd0, oute}, 32'd0);
    check("b2b_accept_addr", {14'd0, addr}, 32'h20);
    core.req = 1'b0;
    k = -1;
    for (int j = 0; j < 50; j++) begin
      if (core.done) begin k = j; break; end
      @(posedge clock); #1;
    end
    check("b2b_read_latency", 32'(k), 32'(2 * N));
    check("b2b_read_rdata", core.rdata, 32'hCAFE_F00D);

    // Random requests against the word-level image.
    for (int i = 0; i < 60; i++) begin
      rw   = 1'($urandom_range(0, 1));
      widx = 17'($urandom_range(0, 31));
      rba  = $urandom;
      rba[18:2] = widx;
      rwd  = $urandom;
      rbe  = 4'($urandom);
      exp_lat  = ((|rbe[3:2]) ? (rw ? N + 2 : N) : 0) + ((|rbe[1:0]) ? (rw ? N + 2 : N) : 0);
      exp_strb = N * (int'(|rbe[3:2]) + int'(|rbe[1:0]));
      if (exp_lat == 0) exp_lat = 1;
      exp_rd = {ref_mem[{widx, 1'b0}] & lanes(rbe[3:2]), ref_mem[{widx, 1'b1}] & lanes(rbe[1:0])};
      run_req(rw, rba, rwd, rbe, tr);
      check($sformatf("rnd%0d_latency", i), 32'(tr.lat), 32'(exp_lat));
      check($sformatf("rnd%0d_strobe_cycles", i), 32'(rw ? tr.wre_lo : tr.oute_lo), 32'(exp_strb));
      if (rw) ref_write(widx, rwd, rbe);
      else check($sformatf("rnd%0d_rdata", i), tr.rd, exp_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
